// File: rtl/alu_functional_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_functional_unit_pkg
// Description : Shared opcode encoding, widths and CDB packet type for the
//               integer functional unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_functional_unit_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_IDX_W = 3;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_func_e;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      value;
        logic [ROB_IDX_W-1:0] rob_idx;
    } cdb_pkt_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_functional_unit_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alu_functional_unit_shifter
// Description : Iterative shifter; moves up to SHIFT_STEP bit positions per
//               cycle and flags done on the cycle of its final step.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_functional_unit_shifter #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic            i_left,
    input  logic            i_arith,
    input  logic [XLEN-1:0] i_data,
    input  logic [4:0]      i_shamt,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam logic [4:0] c_step = 5'(SHIFT_STEP);

    logic [XLEN-1:0] work_q, work_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            running_q, running_d;
    logic            left_q, left_d;
    logic            arith_q, arith_d;
    logic [4:0]      w_step;
    logic [XLEN-1:0] w_shifted;

    always_comb begin
        w_step = (cnt_q < c_step) ? cnt_q : c_step;
        if (left_q) begin
            w_shifted = work_q << w_step;
        end else if (arith_q) begin
            w_shifted = $signed(work_q) >>> w_step;
        end else begin
            w_shifted = work_q >> w_step;
        end
    end

    always_comb begin
        work_d    = work_q;
        cnt_d     = cnt_q;
        running_d = running_q;
        left_d    = left_q;
        arith_d   = arith_q;
        if (i_flush) begin
            running_d = 1'b0;
        end else if (i_start) begin
            work_d    = i_data;
            cnt_d     = i_shamt;
            running_d = (i_shamt != 5'd0);
            left_d    = i_left;
            arith_d   = i_arith;
        end else if (running_q) begin
            work_d    = w_shifted;
            cnt_d     = cnt_q - w_step;
            running_d = (cnt_q != w_step);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q    <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            left_q    <= 1'b0;
            arith_q   <= 1'b0;
        end else begin
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            left_q    <= left_d;
            arith_q   <= arith_d;
        end
    end

    // Done coincides with the last step so the caller can capture o_result.
    assign o_done   = running_q && (cnt_q == w_step);
    assign o_result = w_shifted;

endmodule
`default_nettype wire

// File: rtl/alu_functional_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_functional_unit
// Description : Integer FU: single-cycle ALU plus iterative shifter, holding
//               the tagged result on a CDB request until granted.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_functional_unit #(
    parameter int XLEN       = 32,
    parameter int ROB_IDX_W  = 3,
    parameter int SHIFT_STEP = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    input  logic [XLEN-1:0]      rval1_in,
    input  logic [XLEN-1:0]      rval2_in,
    input  logic [3:0]           opcode_in,
    input  logic [ROB_IDX_W-1:0] rob_idx_in,
    input  logic                 flush_in,
    input  logic                 cdb_grant_in,
    output logic                 fu_busy_out,
    output logic                 cdb_req_out,
    output logic [XLEN-1:0]      cdb_value_out,
    output logic [ROB_IDX_W-1:0] cdb_rob_idx_out,
    output logic                 issue_err_out
);

    import alu_functional_unit_pkg::*;

    localparam logic [1:0] c_state_idle   = 2'd0;
    localparam logic [1:0] c_state_shift  = 2'd1;
    localparam logic [1:0] c_state_result = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [XLEN-1:0]      value_q, value_d;
    logic [ROB_IDX_W-1:0] tag_q, tag_d;
    logic                 err_q, err_d;

    alu_func_e       w_op;
    logic [4:0]      w_shamt;
    logic            w_is_shift;
    logic [XLEN-1:0] w_alu_res;
    logic            w_shift_start;
    logic            w_shift_done;
    logic [XLEN-1:0] w_shift_res;

    assign w_op       = alu_func_e'(opcode_in);
    assign w_shamt    = rval2_in[4:0];
    assign w_is_shift = is_shift_op(opcode_in);

    // Shift opcodes land here only with a zero shift amount.
    always_comb begin
        w_alu_res = '0;
        case (w_op)
            ALU_ADD:  w_alu_res = rval1_in + rval2_in;
            ALU_SUB:  w_alu_res = rval1_in - rval2_in;
            ALU_AND:  w_alu_res = rval1_in & rval2_in;
            ALU_OR:   w_alu_res = rval1_in | rval2_in;
            ALU_XOR:  w_alu_res = rval1_in ^ rval2_in;
            ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(rval1_in) < $signed(rval2_in))};
            ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (rval1_in < rval2_in)};
            ALU_SLL, ALU_SRL, ALU_SRA: w_alu_res = rval1_in;
            default:  w_alu_res = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        value_d       = value_q;
        tag_d         = tag_q;
        err_d         = err_q;
        w_shift_start = 1'b0;
        if (flush_in) begin
            state_d = c_state_idle;
        end else begin
            if (valid_in && (state_q != c_state_idle)) begin
                err_d = 1'b1;
            end
            case (state_q)
                c_state_idle: begin
                    if (valid_in) begin
                        tag_d = rob_idx_in;
                        if (w_is_shift && (w_shamt != 5'd0)) begin
                            w_shift_start = 1'b1;
                            state_d       = c_state_shift;
                        end else begin
                            value_d = w_alu_res;
                            state_d = c_state_result;
                        end
                    end
                end
                c_state_shift: begin
                    if (w_shift_done) begin
                        value_d = w_shift_res;
                        state_d = c_state_result;
                    end
                end
                c_state_result: begin
                    if (cdb_grant_in) begin
                        state_d = c_state_idle;
                    end
                end
                default: state_d = c_state_idle;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= c_state_idle;
            value_q <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
        end
    end

    alu_functional_unit_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk      (clk_in),
        .rst      (rst_in),
        .i_start  (w_shift_start),
        .i_flush  (flush_in),
        .i_left   (w_op == ALU_SLL),
        .i_arith  (w_op == ALU_SRA),
        .i_data   (rval1_in),
        .i_shamt  (w_shamt),
        .o_done   (w_shift_done),
        .o_result (w_shift_res)
    );

    assign fu_busy_out     = (state_q != c_state_idle);
    assign cdb_req_out     = (state_q == c_state_result);
    assign cdb_value_out   = value_q;
    assign cdb_rob_idx_out = tag_q;
    assign issue_err_out   = err_q;

endmodule
`default_nettype wire
